// File: rtl/seg_scan_sched_pkg.sv
// Shared types and constants for the seven-segment scan scheduler.
package seg_pkg;

  typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] ANN_OFF   = 4'hF;

  // Active-low cathode pattern {CG..CA} for each hex nibble
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Nearest enabled index after cur in round-robin order; cur itself is the last candidate
  function automatic logic [1:0] next_en_idx(input logic [1:0] cur, input logic [3:0] en);
    logic [1:0] cand;
    next_en_idx = cur;
    for (int i = 4; i >= 1; i--) begin
      cand = cur + 2'(i);
      if (en[cand]) next_en_idx = cand;
    end
  endfunction

endpackage

// File: rtl/seg_scan_sched_hex_to_seg.sv
// Combinational nibble to active-low seven-segment decoder.
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg_c
);

  assign seg_c = HEX_SEG[nib];

endmodule

// File: rtl/seg_scan_sched.sv
// Four-digit seven-segment scan scheduler with inter-digit blanking and digit masking.
// Optional per-digit blinking is enabled by defining SEG_BLINK_EN.
module seg_scan_sched
  import seg_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 1000,
  parameter int unsigned SHOW_TICKS  = 4,
  parameter int unsigned BLANK_TICKS = 1
`ifdef SEG_BLINK_EN
  ,
  parameter int unsigned BLINK_TICKS = 250
`endif
) (
  input  logic        eclk,
  input  logic        gsr,
  input  logic [15:0] digits_i,
  input  logic [3:0]  dp_i,
  input  logic [3:0]  dig_en,
`ifdef SEG_BLINK_EN
  input  logic [3:0]  blink_i,
`endif
  output logic [3:0]  ann,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic        slot_start
);

  localparam int unsigned PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CMAX = (SHOW_TICKS > BLANK_TICKS) ? SHOW_TICKS : BLANK_TICKS;
  localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_TICKS - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_TICKS - 1);

  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    nib_q, nib_d;
  logic          dpl_q, dpl_d;
  logic          tick;
  logic [1:0]    nidx;
  logic [6:0]    dec_c;
  logic [3:0]    ann_d;
  logic [6:0]    seg_d;
  logic          dp_n_d;
  logic          slot_start_d;

`ifdef SEG_BLINK_EN
  localparam int unsigned BW      = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
  logic          bl_q, bl_d;
  logic          phase_q, phase_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
`endif

  assign tick = (pre_q == PRE_LAST);
  assign nidx = next_en_idx(idx_q, dig_en);

  // Prescaler, slot counter, FSM transitions and per-slot data capture
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    nib_d        = nib_q;
    dpl_d        = dpl_q;
    slot_start_d = 1'b0;
    pre_d        = tick ? '0 : pre_q + PW'(1);
`ifdef SEG_BLINK_EN
    bl_d    = bl_q;
    phase_d = phase_q;
    bcnt_d  = bcnt_q;
    if (tick) begin
      if (bcnt_q == BLINK_LAST) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + BW'(1);
      end
    end
`endif
    if (tick) begin
      case (state_q)
        BLANK: begin
          if (cnt_q != BLANK_LAST) begin
            cnt_d = cnt_q + CW'(1);
          end else if (dig_en != 4'b0000) begin
            state_d      = SHOW;
            idx_d        = nidx;
            cnt_d        = '0;
            nib_d        = digits_i[{nidx, 2'b00} +: 4];
            dpl_d        = dp_i[nidx];
            slot_start_d = 1'b1;
`ifdef SEG_BLINK_EN
            bl_d         = blink_i[nidx];
`endif
          end
        end
        SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            state_d = BLANK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = BLANK;
      endcase
    end
  end

  hex_to_seg u_hex_to_seg (
    .nib   (nib_d),
    .seg_c (dec_c)
  );

  // Next output values follow the next state so pins change on the same edge
  always_comb begin
    ann_d  = ANN_OFF;
    seg_d  = SEG_BLANK;
    dp_n_d = 1'b1;
    if (state_d == SHOW) begin
      ann_d  = ~(4'b0001 << idx_d);
      seg_d  = dec_c;
      dp_n_d = ~dpl_d;
`ifdef SEG_BLINK_EN
      if (!phase_d && bl_d) begin
        seg_d  = SEG_BLANK;
        dp_n_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge eclk or posedge gsr) begin
    if (gsr) begin
      state_q    <= BLANK;
      idx_q      <= 2'd3;
      pre_q      <= '0;
      cnt_q      <= '0;
      nib_q      <= '0;
      dpl_q      <= 1'b0;
      ann        <= ANN_OFF;
      seg        <= SEG_BLANK;
      dp_n       <= 1'b1;
      slot_start <= 1'b0;
`ifdef SEG_BLINK_EN
      bl_q       <= 1'b0;
      phase_q    <= 1'b1;
      bcnt_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pre_q      <= pre_d;
      cnt_q      <= cnt_d;
      nib_q      <= nib_d;
      dpl_q      <= dpl_d;
      ann        <= ann_d;
      seg        <= seg_d;
      dp_n       <= dp_n_d;
      slot_start <= slot_start_d;
`ifdef SEG_BLINK_EN
      bl_q       <= bl_d;
      phase_q    <= phase_d;
      bcnt_q     <= bcnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_seg_scan_sched.sv
// Directed bench for seg_scan_sched with TICK_DIV=2, SHOW_TICKS=2, BLANK_TICKS=1 (BLINK_TICKS=8 with SEG_BLINK_EN).
module tb_seg_scan_sched;

  logic        eclk = 1'b0;
  logic        gsr  = 1'b1;
  logic [15:0] digits_i = 16'h1234;
  logic [3:0]  dp_i   = 4'b0000;
  logic [3:0]  dig_en = 4'b1111;
  logic [3:0]  blink_i = 4'b0000;
  logic [3:0]  ann;
  logic [6:0]  seg;
  logic        dp_n;
  logic        slot_start;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 eclk = ~eclk;

`ifdef SEG_BLINK_EN
  seg_scan_sched #(.TICK_DIV(2), .SHOW_TICKS(2), .BLANK_TICKS(1), .BLINK_TICKS(8)) dut (
    .eclk(eclk), .gsr(gsr), .digits_i(digits_i), .dp_i(dp_i), .dig_en(dig_en),
    .blink_i(blink_i), .ann(ann), .seg(seg), .dp_n(dp_n), .slot_start(slot_start));
`else
  seg_scan_sched #(.TICK_DIV(2), .SHOW_TICKS(2), .BLANK_TICKS(1)) dut (
    .eclk(eclk), .gsr(gsr), .digits_i(digits_i), .dp_i(dp_i), .dig_en(dig_en),
    .ann(ann), .seg(seg), .dp_n(dp_n), .slot_start(slot_start));
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] hexseg(input logic [3:0] n);
    case (n)
      4'h0: hexseg = 7'h40;  4'h1: hexseg = 7'h79;  4'h2: hexseg = 7'h24;  4'h3: hexseg = 7'h30;
      4'h4: hexseg = 7'h19;  4'h5: hexseg = 7'h12;  4'h6: hexseg = 7'h02;  4'h7: hexseg = 7'h78;
      4'h8: hexseg = 7'h00;  4'h9: hexseg = 7'h10;  4'hA: hexseg = 7'h08;  4'hB: hexseg = 7'h03;
      4'hC: hexseg = 7'h46;  4'hD: hexseg = 7'h21;  4'hE: hexseg = 7'h06;  default: hexseg = 7'h0E;
    endcase
  endfunction

  task automatic reset_dut();
    gsr = 1'b1;
    repeat (2) @(negedge eclk);
    gsr = 1'b0;
  endtask

  // Cycle c is observed after the c-th rising edge since reset release.
  // Slots begin at c=2 and recur every 6 cycles: 4 lit, 2 blank.
  task automatic run_model(input string tag, input int ncyc, input int chg_cyc, input logic [15:0] chg_val);
    int cur;
    int p;
    logic [3:0] nib;
    logic dpl;
    logic bl;
    logic [12:0] exp;
    cur = 3; nib = 4'h0; dpl = 1'b0; bl = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge eclk);
      @(negedge eclk);
      exp = {4'hF, 7'h7F, 1'b1, 1'b0};
      if (c >= 2 && dig_en != 4'b0000) begin
        p = (c - 2) % 6;
        if (p == 0) begin
          for (int k = 1; k <= 4; k++) begin
            if (dig_en[(cur + k) % 4]) begin
              cur = (cur + k) % 4;
              break;
            end
          end
          nib = digits_i[cur*4 +: 4];
          dpl = dp_i[cur];
          bl  = blink_i[cur];
        end
        if (p < 4) begin
          exp[12:9] = ~(4'b0001 << cur);
          exp[8:2]  = hexseg(nib);
          exp[1]    = ~dpl;
          exp[0]    = (p == 0);
`ifdef SEG_BLINK_EN
          if (bl && ((c / 16) % 2 == 1)) begin
            exp[8:2] = 7'h7F;
            exp[1]   = 1'b1;
          end
`endif
        end
      end
      check($sformatf("%s c%0d", tag, c), {19'b0, ann, seg, dp_n, slot_start}, {19'b0, exp});
      if (c == chg_cyc) digits_i = chg_val;
    end
  endtask

  initial begin
    // Reset hold with toggling data
    for (int i = 0; i < 5; i++) begin
      @(negedge eclk);
      digits_i = digits_i ^ 16'hA5A5;
      check($sformatf("rst_hold %0d", i), {19'b0, ann, seg, dp_n, slot_start}, {19'b0, 4'hF, 7'h7F, 1'b1, 1'b0});
    end
    digits_i = 16'h1234;
    dp_i     = 4'b0100;
    gsr      = 1'b0;
    run_model("rot", 30, 0, 16'h0);

    // Mask skip and all-disabled
    dig_en = 4'b0101;
    reset_dut();
    run_model("mask", 26, 0, 16'h0);
    dig_en = 4'b0000;
    reset_dut();
    run_model("off", 20, 0, 16'h0);

    // Single digit with mid-slot data change
    dp_i   = 4'b0000;
    dig_en = 4'b0001;
    reset_dut();
    run_model("data", 16, 3, 16'h1238);

    // Asynchronous reset during digit 2's slot
    digits_i = 16'h1234;
    dig_en   = 4'b1111;
    reset_dut();
    run_model("pre_rst", 15, 0, 16'h0);
    gsr = 1'b1;
    #1;
    check("async_rst", {19'b0, ann, seg, dp_n, slot_start}, {19'b0, 4'hF, 7'h7F, 1'b1, 1'b0});
    @(negedge eclk);
    gsr = 1'b0;
    run_model("post_rst", 8, 0, 16'h0);

`ifdef SEG_BLINK_EN
    blink_i = 4'b0001;
    reset_dut();
    run_model("blink", 56, 0, 16'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
